// File: rtl/exu_div_ctrl.sv
// Iterative RV32M divide sequencer: 32-step radix-2 restoring division for DIV/DIVU/REM/REMU.
// Holds the pipeline via stallreq_o and delivers one result beat with its destination register.
module exu_div_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic [4:0]            rd_addr_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  ready_o,
    output logic [4:0]            rd_addr_o,
    output logic                  busy_o,
    output logic                  stallreq_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [DATA_WIDTH-1:0] MinNeg   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  LastStep = CNT_WIDTH'(DATA_WIDTH - 1);

    state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0]   rq_q, rq_d;
    logic [DATA_WIDTH-1:0]     divisor_q, divisor_d;
    logic                      rem_sel_q, rem_sel_d;
    logic                      quo_neg_q, quo_neg_d;
    logic                      rem_neg_q, rem_neg_d;
    logic [4:0]                rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     result_q, result_d;
    logic [4:0]                rd_out_q, rd_out_d;

    logic                      is_signed;
    logic [DATA_WIDTH-1:0]     abs_dividend, abs_divisor;
    logic [DATA_WIDTH:0]       step_diff;
    logic [2*DATA_WIDTH-1:0]   step_rq;
    logic [DATA_WIDTH-1:0]     fin_quo, fin_rem;

    assign is_signed    = ~op_i[0];
    assign abs_dividend = (is_signed && dividend_i[DATA_WIDTH-1]) ? -dividend_i : dividend_i;
    assign abs_divisor  = (is_signed && divisor_i[DATA_WIDTH-1])  ? -divisor_i  : divisor_i;

    // Partial remainder needs 33 bits after the shift when the divisor exceeds 2^31.
    assign step_diff = rq_q[2*DATA_WIDTH-1:DATA_WIDTH-1] - {1'b0, divisor_q};
    assign step_rq   = step_diff[DATA_WIDTH]
                     ? {rq_q[2*DATA_WIDTH-2:DATA_WIDTH-1], rq_q[DATA_WIDTH-2:0], 1'b0}
                     : {step_diff[DATA_WIDTH-1:0], rq_q[DATA_WIDTH-2:0], 1'b1};
    assign fin_quo   = quo_neg_q ? -step_rq[DATA_WIDTH-1:0] : step_rq[DATA_WIDTH-1:0];
    assign fin_rem   = rem_neg_q ? -step_rq[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : step_rq[2*DATA_WIDTH-1:DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rq_q      <= '0;
            divisor_q <= '0;
            rem_sel_q <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            rd_q      <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rq_q      <= rq_d;
            divisor_q <= divisor_d;
            rem_sel_q <= rem_sel_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rq_d      = rq_q;
        divisor_d = divisor_q;
        rem_sel_d = rem_sel_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        rd_d      = rd_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    rem_sel_d = op_i[1];
                    rd_d      = rd_addr_i;
                    if (divisor_i == '0) begin
                        result_d = op_i[1] ? dividend_i : '1;
                        rd_out_d = rd_addr_i;
                        state_d  = StDone;
                    end else if (is_signed && dividend_i == MinNeg && divisor_i == '1) begin
                        result_d = op_i[1] ? '0 : MinNeg;
                        rd_out_d = rd_addr_i;
                        state_d  = StDone;
                    end else begin
                        rq_d      = {{DATA_WIDTH{1'b0}}, abs_dividend};
                        divisor_d = abs_divisor;
                        quo_neg_d = is_signed &
                                    (dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1]);
                        rem_neg_d = is_signed & dividend_i[DATA_WIDTH-1];
                        cnt_d     = '0;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                rq_d  = step_rq;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    result_d = rem_sel_q ? fin_rem : fin_quo;
                    rd_out_d = rd_q;
                    cnt_d    = '0;
                    state_d  = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Flush wins over everything, including a same-cycle start and result capture.
        if (flush_i) begin
            state_d  = StIdle;
            cnt_d    = '0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    assign result_o   = result_q;
    assign rd_addr_o  = rd_out_q;
    assign ready_o    = (state_q == StDone) & ~flush_i;
    assign busy_o     = (state_q == StCalc) | (state_q == StDone);
    assign stallreq_o = rst_n & ~flush_i &
                        (((state_q == StIdle) & start_i) | (state_q == StCalc));

endmodule
